// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the core and the multi-cycle RV32M sequencer.
// The core drives the master side; the sequencer owns the slave side.
interface muldiv_sequencer_if #(parameter int XLEN = 32) ();
    logic            start_valid;
    logic            start_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output start_valid, op, operand_a, operand_b, flush, result_ready,
        input  start_ready, result_valid, result, busy
    );

    modport slave (
        input  start_valid, op, operand_a, operand_b, flush, result_ready,
        output start_ready, result_valid, result, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Bit-serial RV32M multiply/divide: shift-add multiply, restoring divide,
// with divide-by-zero and signed-overflow answered directly at acceptance.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic clock,
    input  logic reset_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dmag;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*XLEN-1:0] acc;     // {hi, multiplier} for MUL; low half is quotient for DIV
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] result_q;

    logic            accept, sa, sb, neg_in, special;
    logic [XLEN-1:0] amag, bmag, special_res;

    always_comb begin
        accept = (state == IDLE) && bus.start_valid && !bus.flush;
        sa = bus.operand_a[XLEN-1] && (bus.op inside {3'b001, 3'b010, 3'b100, 3'b110});
        sb = bus.operand_b[XLEN-1] && (bus.op inside {3'b001, 3'b100, 3'b110});
        amag = sa ? -bus.operand_a : bus.operand_a;
        bmag = sb ? -bus.operand_b : bus.operand_b;
        case (bus.op)
            3'b001, 3'b100: neg_in = sa ^ sb;
            3'b010, 3'b110: neg_in = sa;
            default:        neg_in = 1'b0;
        endcase
        special = bus.op[2] && ((bus.operand_b == '0) ||
                  (!bus.op[0] && bus.operand_a == SMIN && bus.operand_b == '1));
        if (bus.operand_b == '0)
            special_res = bus.op[1] ? bus.operand_a : '1;
        else
            special_res = bus.op[1] ? '0 : SMIN;
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_mul, prod;
    logic [XLEN+1:0]   shifted, diff;
    logic              qbit;
    logic [XLEN:0]     rem_div;
    logic [XLEN-1:0]   quo_div, quo_f, rem_f, mul_sel, div_sel;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dmag} : {(XLEN+1){1'b0}});
        acc_mul = {mul_sum, acc[XLEN-1:1]};
        prod    = neg_q ? -acc_mul : acc_mul;
        mul_sel = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        // Remainder stays below the divisor, so the top bit of diff is a clean borrow.
        shifted = {rem, acc[XLEN-1]};
        diff    = shifted - {2'b00, dmag};
        qbit    = ~diff[XLEN+1];
        rem_div = qbit ? diff[XLEN:0] : shifted[XLEN:0];
        quo_div = {acc[XLEN-2:0], qbit};
        quo_f   = neg_q ? -quo_div : quo_div;
        rem_f   = neg_q ? -rem_div[XLEN-1:0] : rem_div[XLEN-1:0];
        div_sel = op_q[1] ? rem_f : quo_f;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : (bus.op[2] ? DIV : MUL);
            MUL,
            DIV:  if (cnt == '0) state_nxt = DONE;
            DONE: if (bus.result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt      <= '0;
            dmag     <= '0;
            acc      <= '0;
            rem      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= bus.op;
                    neg_q <= neg_in;
                    cnt   <= CW'(XLEN-1);
                    dmag  <= bus.op[2] ? bmag : amag;
                    acc   <= {{XLEN{1'b0}}, (bus.op[2] ? amag : bmag)};
                    rem   <= '0;
                    if (special) result_q <= special_res;
                end
                MUL: begin
                    acc <= acc_mul;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) result_q <= mul_sel;
                end
                DIV: begin
                    acc[XLEN-1:0] <= quo_div;
                    rem <= rem_div;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) result_q <= div_sel;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.start_ready  = (state == IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.result       = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: result values, latency,
// backpressure, flush and asynchronous reset.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request for one edge; afterwards scramble inputs to prove capture.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_valid = 1'b1;
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clock);
        #1;
        bus.start_valid = 1'b0;
        bus.op = ~op;
        bus.operand_a = ~a;
        bus.operand_b = a ^ b;
    endtask

    // Edges counted from the acceptance edge (inclusive) until result_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.result_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        issue(v.op, v.a, v.b);
        wait_valid(lat);
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d result", idx), bus.result, v.exp);
        bus.result_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.result_ready = 1'b0;
        check($sformatf("v%0d idle", idx), {30'd0, bus.result_valid, bus.start_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vecs[2]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 33};
        vecs[3]  = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 33};
        vecs[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[5]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[6]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[7]  = '{3'b000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 33};
        vecs[8]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33};
        vecs[9]  = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33};
        vecs[10] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[11] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[12] = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
        vecs[13] = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
        vecs[14] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[15] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[16] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
        vecs[17] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[18] = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
        vecs[19] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[20] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
        vecs[21] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[22] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[23] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[24] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[25] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};

        bus.start_valid = 1'b0;
        bus.op = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.flush = 1'b0;
        bus.result_ready = 1'b0;

        #1 reset_n = 1'b0;
        #2;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset start_ready", {31'd0, bus.start_ready}, 32'd1);
        check("reset result_valid", {31'd0, bus.result_valid}, 32'd0);
        check("reset result", bus.result, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 26; i++) run_vec(vecs[i], i);

        // Backpressure: result held, start_valid ignored while DONE.
        issue(3'b101, 32'd100, 32'd7);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'd33);
        bus.start_valid = 1'b1;
        bus.op = 3'b000;
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("bp hold%0d result", i), bus.result, 32'd14);
            check($sformatf("bp hold%0d flags", i),
                  {29'd0, bus.result_valid, bus.start_ready, bus.busy}, 32'b101);
        end
        bus.start_valid = 1'b0;
        bus.result_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.result_ready = 1'b0;
        check("bp release flags", {29'd0, bus.result_valid, bus.start_ready, bus.busy}, 32'b010);
        @(posedge clock);
        #1;
        check("bp no late accept", {31'd0, bus.busy}, 32'd0);

        // Flush on the 10th iteration cycle.
        issue(3'b000, 32'd5, 32'd6);
        repeat (9) @(posedge clock);
        #1 bus.flush = 1'b1;
        @(posedge clock);
        #1 bus.flush = 1'b0;
        check("flush mid flags", {29'd0, bus.result_valid, bus.start_ready, bus.busy}, 32'b010);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.result_valid) seen = 1'b1;
        end
        check("flush no result", {31'd0, seen}, 32'd0);
        run_vec('{3'b000, 32'd5, 32'd6, 32'd30, 33}, 100);

        // Flush beats start_valid in IDLE.
        bus.start_valid = 1'b1;
        bus.op = 3'b101;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd0;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.start_valid = 1'b0;
        bus.flush = 1'b0;
        check("flush idle busy", {31'd0, bus.busy}, 32'd0);

        // Flush beats result_ready in DONE.
        issue(3'b101, 32'd9, 32'd0);
        check("flush done pre", {31'd0, bus.result_valid}, 32'd1);
        bus.flush = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        bus.result_ready = 1'b0;
        check("flush done flags", {29'd0, bus.result_valid, bus.start_ready, bus.busy}, 32'b010);

        // Asynchronous reset in the middle of a divide.
        run_vec('{3'b111, 32'd100, 32'd7, 32'd2, 33}, 101);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("areset flags", {29'd0, bus.result_valid, bus.start_ready, bus.busy}, 32'b010);
        check("areset result", bus.result, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.result_valid || bus.busy) seen = 1'b1;
        end
        check("areset no result", {31'd0, seen}, 32'd0);
        run_vec('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33}, 102);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for RV32M multiply/divide operations.
- Sits beside the single-cycle ALU. It accepts an M-extension operation selected by funct3, together with two operands, and iterates one bit per cycle.
- It returns the result through a valid/ready handshake. The core holds its pipeline stall while `busy` is high.
- It owns all RISC-V corner-case semantics: divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- start_valid  in  1  request present
- start_ready  out  1  sequencer can accept a request
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  XLEN  rs1 value (multiplicand / dividend)
- operand_b  in  XLEN  rs2 value (multiplier / divisor)
- flush  in  1  synchronous abort of any operation in flight
- result_valid  out  1  result available
- result_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: start_ready=1.
  - MUL: iterative shift-add.
  - DIV: iterative restoring division.
  - DONE: result_valid=1.
- Reset (reset_n low, asynchronous):
  - state=IDLE.
  - result_valid=0, result=0, busy=0, start_ready=1.
  - Counter and internal registers cleared.
- Acceptance:
  - A request is accepted at a rising edge where state=IDLE, start_valid=1 and flush=0.
  - op and operands are captured at that edge; later input changes are ignored.
- Sign handling at acceptance:
  - Signed operands are converted to magnitudes. Signed: MULH both; MULHSU operand_a only; DIV/REM both.
  - The result sign is recorded:
    - MUL/MULH: sign_a XOR sign_b.
    - MULHSU: sign_a.
    - DIV: sign_a XOR sign_b.
    - REM: sign_a.
  - MUL yields the low XLEN bits, which are sign-independent. It may use signed-magnitude flow or unsigned flow; the result is identical.
- MUL state:
  - 2*XLEN-bit accumulator.
  - One multiplier bit per cycle, LSB first, for XLEN cycles.
  - The counter runs from XLEN-1 down to 0.
- DIV state:
  - Restoring division, one quotient bit per cycle, MSB first, for XLEN cycles.
  - Remainder register is XLEN+1 bits.
- Transition to DONE:
  - On the edge ending the final iteration, state becomes DONE.
  - The registered result receives the selected half (MUL low; MULH/MULHSU/MULHU high; DIV/DIVU quotient; REM/REMU remainder).
  - For signed ops with negative result sign, the full 2*XLEN product or the quotient/remainder is negated before selection.
- Latency: result_valid rises XLEN+1 edges after the acceptance edge (33 cycles at XLEN=32).
- Special cases are detected at acceptance and go straight to DONE, so result_valid rises 1 edge after acceptance.
  - Divisor=0:
    - DIV/DIVU: result = all ones.
    - REM/REMU: result = operand_a.
  - DIV/REM with operand_a = 0x80000000 and operand_b = 0xFFFFFFFF:
    - DIV: result = 0x80000000.
    - REM: result = 0.
  - Multiplications by zero are not special-cased; they take full latency.
- DONE state:
  - result is held stable while result_valid=1 and result_ready=0.
  - On an edge with result_ready=1, state becomes IDLE and result_valid becomes 0.
  - A new request cannot be accepted in the same cycle as the result handshake; start_ready is high only in IDLE. Minimum issue interval is therefore XLEN+2 cycles.
- flush:
  - From any state, flush=1 at an edge sets state to IDLE, result_valid to 0 and busy to 0.
  - flush beats start_valid in IDLE, so no request is accepted.
  - flush beats result_ready in DONE; the result is discarded.
  - result retains its last value but is meaningless while result_valid=0.
- busy = (state != IDLE); start_ready = (state == IDLE). Both are decoded from registered state.
- Asynchronous reset mid-operation behaves identically to reset at idle; no partial result escapes.

Test Plan:
- MUL, operand_a=7, operand_b=0xFFFFFFFD (-3) -> result_valid exactly 33 cycles after acceptance, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD after 33 cycles; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corner cases, each with result_valid one cycle after acceptance:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold result_ready=0 for 5 cycles in DONE -> result and result_valid stable, start_valid ignored. Assert result_ready -> IDLE next edge, start_ready=1.
- Flush and reset:
  - flush asserted on the 10th iteration cycle -> IDLE next edge, result_valid never asserted, next request completes correctly.
  - reset_n pulsed low mid-DIV asynchronously -> all outputs at reset values immediately.
